// File: rtl/puc_pkg.sv
// Shared program-counter-unit definitions: PC operation codes and the default
// instruction address width used by the PC and the return-address stack.
package puc_pkg;

    typedef enum logic [1:0] {
        OP_RESET = 2'd0,
        OP_JMP   = 2'd1,
        OP_RET   = 2'd2,
        OP_NEXT  = 2'd3
    } op_code_t;

    localparam int INSTR_ADDR_SIZE_DEF = 5;

endpackage

// File: rtl/ret_addr_stack_if.sv
// Call/return bus between the PC (master) and the return-address stack (slave).
interface ret_addr_stack_if
    import puc_pkg::*;
#(
    parameter int INSTR_ADDR_SIZE = INSTR_ADDR_SIZE_DEF,
    parameter int STACK_DEPTH     = 4
) ();

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic                       PUSH;
    logic                       POP;
    logic [INSTR_ADDR_SIZE-1:0] INSTR_ADDR;
    logic [INSTR_ADDR_SIZE-1:0] RET_ADDR;
    logic [DEPTH_W-1:0]         DEPTH;
    logic                       EMPTY;
    logic                       FULL;
    logic                       OVERFLOW;
    logic                       UNDERFLOW;

    modport master (
        output PUSH, POP, INSTR_ADDR,
        input  RET_ADDR, DEPTH, EMPTY, FULL, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  PUSH, POP, INSTR_ADDR,
        output RET_ADDR, DEPTH, EMPTY, FULL, OVERFLOW, UNDERFLOW
    );

endinterface

// File: rtl/ret_addr_stack.sv
// Return-address stack feeding the PC: push INSTR_ADDR+1 on call, pop on return.
// Define RET_STACK_WRAP_EN to let a push while full overwrite the oldest entry.
module ret_addr_stack
    import puc_pkg::*;
#(
    parameter int INSTR_ADDR_SIZE = INSTR_ADDR_SIZE_DEF,
    parameter int STACK_DEPTH     = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    ret_addr_stack_if.slave  bus
);

    localparam int PTR_W   = $clog2(STACK_DEPTH);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

    logic [INSTR_ADDR_SIZE-1:0] mem_q [STACK_DEPTH];
    logic [INSTR_ADDR_SIZE-1:0] mem_d [STACK_DEPTH];
    logic [PTR_W-1:0]           ptr_q, ptr_d;
    logic [DEPTH_W-1:0]         depth_q, depth_d;
    logic                       ovf_q, ovf_d;
    logic                       udf_q, udf_d;

    logic [PTR_W-1:0]           top_idx;
    logic [INSTR_ADDR_SIZE-1:0] push_val;
    logic                       empty;
    logic                       full;

    // ptr_q is the next free slot; the live top sits one below it (mod depth)
    assign top_idx  = ptr_q - 1'b1;
    assign push_val = bus.INSTR_ADDR + 1'b1;
    assign empty    = (depth_q == '0);
    assign full     = (depth_q == DEPTH_MAX);

    always_comb begin
        mem_d   = mem_q;
        ptr_d   = ptr_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;

        if (bus.PUSH && bus.POP && !empty) begin
            mem_d[top_idx] = push_val;
        end else if (bus.PUSH) begin
            if (bus.POP) begin
                udf_d = 1'b1;
            end
            if (!full) begin
                mem_d[ptr_q] = push_val;
                ptr_d        = ptr_q + 1'b1;
                depth_d      = depth_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
`ifdef RET_STACK_WRAP_EN
                // When full the next free slot holds the oldest entry
                mem_d[ptr_q] = push_val;
                ptr_d        = ptr_q + 1'b1;
`endif
            end
        end else if (bus.POP) begin
            if (empty) begin
                udf_d = 1'b1;
            end else begin
                ptr_d   = ptr_q - 1'b1;
                depth_d = depth_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            ptr_q   <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            ptr_q   <= ptr_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign bus.RET_ADDR  = empty ? '0 : mem_q[top_idx];
    assign bus.DEPTH     = depth_q;
    assign bus.EMPTY     = empty;
    assign bus.FULL      = full;
    assign bus.OVERFLOW  = ovf_q;
    assign bus.UNDERFLOW = udf_q;

endmodule

// File: tb/tb_ret_addr_stack.sv
// Bench for ret_addr_stack: directed vector table, corner-case sequences and
// random traffic compared against a queue-based model of the stack.
module tb_ret_addr_stack;

    localparam int AW = 5;
    localparam int SD = 4;

    logic CLK;
    logic RST_N;

    ret_addr_stack_if #(.INSTR_ADDR_SIZE(AW), .STACK_DEPTH(SD)) bus ();

    ret_addr_stack #(.INSTR_ADDR_SIZE(AW), .STACK_DEPTH(SD)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int nvec;
    int nfail;

    // Reference model: queue, back = top of stack
    logic [AW-1:0] m_q[$];
    bit            m_ovf;
    bit            m_udf;

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic model_step(input bit push, input bit pop, input logic [AW-1:0] a);
        logic [AW-1:0] v;
        v = a + 1'b1;
        if (push && pop && m_q.size() > 0) begin
            m_q[m_q.size()-1] = v;
        end else if (push) begin
            if (pop) m_udf = 1'b1;
            if (m_q.size() < SD) begin
                m_q.push_back(v);
            end else begin
                m_ovf = 1'b1;
`ifdef RET_STACK_WRAP_EN
                void'(m_q.pop_front());
                m_q.push_back(v);
`endif
            end
        end else if (pop) begin
            if (m_q.size() == 0) m_udf = 1'b1;
            else void'(m_q.pop_back());
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [AW-1:0] top;
        top = (m_q.size() > 0) ? m_q[m_q.size()-1] : '0;
        chk({tag, ".ret"},   32'(bus.RET_ADDR),  32'(top));
        chk({tag, ".depth"}, 32'(bus.DEPTH),     32'(m_q.size()));
        chk({tag, ".empty"}, 32'(bus.EMPTY),     32'(m_q.size() == 0));
        chk({tag, ".full"},  32'(bus.FULL),      32'(m_q.size() == SD));
        chk({tag, ".ovf"},   32'(bus.OVERFLOW),  32'(m_ovf));
        chk({tag, ".udf"},   32'(bus.UNDERFLOW), 32'(m_udf));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ret"},   32'(bus.RET_ADDR),  32'd0);
        chk({tag, ".depth"}, 32'(bus.DEPTH),     32'd0);
        chk({tag, ".empty"}, 32'(bus.EMPTY),     32'd1);
        chk({tag, ".full"},  32'(bus.FULL),      32'd0);
        chk({tag, ".ovf"},   32'(bus.OVERFLOW),  32'd0);
        chk({tag, ".udf"},   32'(bus.UNDERFLOW), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N          = 1'b0;
        bus.PUSH       = 1'b0;
        bus.POP        = 1'b0;
        bus.INSTR_ADDR = '0;
        model_reset();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    // Drive at the falling edge, update model at the rising edge, sample 1 time unit later
    task automatic apply(input bit push, input bit pop, input logic [AW-1:0] a);
        @(negedge CLK);
        bus.PUSH       = push;
        bus.POP        = pop;
        bus.INSTR_ADDR = a;
        @(posedge CLK);
        model_step(push, pop, a);
        #1;
        bus.PUSH = 1'b0;
        bus.POP  = 1'b0;
    endtask

    typedef struct {
        bit            push;
        bit            pop;
        logic [AW-1:0] addr;
        logic [AW-1:0] exp_ret;
        int            exp_depth;
        bit            exp_empty;
        bit            exp_full;
        bit            exp_ovf;
        bit            exp_udf;
    } vec_t;

    vec_t vecs[6];

    initial begin
        nvec  = 0;
        nfail = 0;
        RST_N = 1'b0;
        bus.PUSH = 1'b0;
        bus.POP  = 1'b0;
        bus.INSTR_ADDR = '0;
        model_reset();

        vecs[0] = '{1'b1, 1'b0, 5'd3,  5'd4,  1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 5'd9,  5'd10, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 5'd0,  5'd4,  1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 5'd20, 5'd21, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 5'd0,  5'd0,  0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 5'd0,  5'd0,  0, 1'b1, 1'b0, 1'b0, 1'b1};

        do_reset();
        #1;
        chk_reset_vals("reset");

        for (int i = 0; i < 6; i++) begin
            apply(vecs[i].push, vecs[i].pop, vecs[i].addr);
            chk($sformatf("vec%0d.ret", i),   32'(bus.RET_ADDR),  32'(vecs[i].exp_ret));
            chk($sformatf("vec%0d.depth", i), 32'(bus.DEPTH),     32'(vecs[i].exp_depth));
            chk($sformatf("vec%0d.empty", i), 32'(bus.EMPTY),     32'(vecs[i].exp_empty));
            chk($sformatf("vec%0d.full", i),  32'(bus.FULL),      32'(vecs[i].exp_full));
            chk($sformatf("vec%0d.ovf", i),   32'(bus.OVERFLOW),  32'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d.udf", i),   32'(bus.UNDERFLOW), 32'(vecs[i].exp_udf));
        end

        // Underflow flag is sticky across later good traffic
        apply(1'b1, 1'b0, 5'd7);
        chk("udf_sticky", 32'(bus.UNDERFLOW), 32'd1);
        chk("udf_sticky.ret", 32'(bus.RET_ADDR), 32'd8);
        // PUSH & POP while empty behaves as a push and flags underflow
        do_reset();
        apply(1'b1, 1'b1, 5'd12);
        chk("pp_empty.ret",   32'(bus.RET_ADDR),  32'd13);
        chk("pp_empty.depth", 32'(bus.DEPTH),     32'd1);
        chk("pp_empty.udf",   32'(bus.UNDERFLOW), 32'd1);

        // Five pushes into a four-deep stack, then drain
        do_reset();
        for (int i = 1; i <= 5; i++) apply(1'b1, 1'b0, AW'(i));
        chk("ovf.flag",  32'(bus.OVERFLOW), 32'd1);
        chk("ovf.depth", 32'(bus.DEPTH),    32'd4);
        chk("ovf.full",  32'(bus.FULL),     32'd1);
`ifdef RET_STACK_WRAP_EN
        chk("ovf.ret", 32'(bus.RET_ADDR), 32'd6);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d", i), 32'(bus.RET_ADDR), 32'(6 - i));
            apply(1'b0, 1'b1, '0);
        end
`else
        chk("ovf.ret", 32'(bus.RET_ADDR), 32'd5);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d", i), 32'(bus.RET_ADDR), 32'(5 - i));
            apply(1'b0, 1'b1, '0);
        end
`endif
        chk("drain.empty", 32'(bus.EMPTY), 32'd1);
        chk("drain.ovf",   32'(bus.OVERFLOW), 32'd1);

        // Address wrap, then asynchronous reset mid-cycle
        do_reset();
        apply(1'b1, 1'b0, 5'd31);
        chk("wrap.ret",   32'(bus.RET_ADDR), 32'd0);
        chk("wrap.depth", 32'(bus.DEPTH),    32'd1);
        apply(1'b1, 1'b0, 5'd4);
        chk("pre_rst.ret", 32'(bus.RET_ADDR), 32'd5);
        #2;
        bus.PUSH = 1'b1;
        bus.INSTR_ADDR = 5'd17;
        RST_N = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(posedge CLK);
        #1;
        chk_reset_vals("rst_held");
        @(negedge CLK);
        bus.PUSH = 1'b0;
        RST_N = 1'b1;
        model_reset();

        // Random traffic with periodic resets
        for (int n = 0; n < 400; n++) begin
            if (n % 100 == 99) begin
                do_reset();
                #1;
                chk_model("rnd_rst");
            end else begin
                apply(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), AW'($urandom));
                chk_model($sformatf("rnd%0d", n));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
